// File: rtl/sdram_burst_scheduler.sv
// sdram_burst_scheduler
//   Shares one SDRAM controller command port among four FIFO-side requesters:
//   0 camera write, 1 display read, 2 image-transfer read, 3 image-transfer
//   write-back. Each port has an address pointer that walks from its start
//   address toward its exclusive max address in bursts of port_len words.
//   Arbitration is round-robin, with an urgent override for URGENT_PORT.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   port_req          per-port level request
//   port_urgent       per-port urgent flag (only URGENT_PORT honoured)
//   port_is_write     per-port burst direction (1 = write)
//   port_start_addr   per-port start address, port i at [i*ASIZE +: ASIZE]
//   port_max_addr     per-port exclusive upper bound
//   port_len          per-port burst length (0 = request ignored)
//   port_clear        per-port pulse, reloads pointer with start address
//   port_grant        one-hot, command issue through burst completion
//   port_wrap         one-cycle pulse when a pointer wraps to start
//   cmd_valid/cmd_write/cmd_addr/cmd_len   burst command to controller
//   cmd_ack           controller accepts command
//   cmd_done          end of accepted burst
//   busy              scheduler not idle
module sdram_burst_scheduler #(
  parameter int ASIZE       = 23,
  parameter int LEN_W       = 11,
  parameter int URGENT_PORT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           port_req,
  input  logic [3:0]           port_urgent,
  input  logic [3:0]           port_is_write,
  input  logic [4*ASIZE-1:0]   port_start_addr,
  input  logic [4*ASIZE-1:0]   port_max_addr,
  input  logic [4*LEN_W-1:0]   port_len,
  input  logic [3:0]           port_clear,
  output logic [3:0]           port_grant,
  output logic [3:0]           port_wrap,
  output logic                 cmd_valid,
  output logic                 cmd_write,
  output logic [ASIZE-1:0]     cmd_addr,
  output logic [LEN_W-1:0]     cmd_len,
  input  logic                 cmd_ack,
  input  logic                 cmd_done,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT_DONE} state_t;

  localparam logic [1:0] URG_IDX  = 2'(URGENT_PORT);
  localparam logic [3:0] URG_MASK = 4'b0001 << URGENT_PORT;

  state_t state, state_nxt;

  logic [ASIZE-1:0] start_a [4];
  logic [ASIZE-1:0] max_a   [4];
  logic [LEN_W-1:0] len_a   [4];
  logic [ASIZE-1:0] ptr     [4];
  logic [3:0]       elig;
  logic [3:0]       clr_pend;
  logic [1:0]       last_grant;
  logic [1:0]       winner;

  logic             urgent_hit;
  logic             arb_found;
  logic [1:0]       arb_idx;
  logic [1:0]       cand;

  logic [ASIZE:0]   len_ext;
  logic [ASIZE:0]   ptr_next;
  logic [ASIZE:0]   ptr_check;
  logic             wrap_now;
  logic             clear_now;

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    assign start_a[g] = port_start_addr[g*ASIZE +: ASIZE];
    assign max_a[g]   = port_max_addr[g*ASIZE +: ASIZE];
    assign len_a[g]   = port_len[g*LEN_W +: LEN_W];
    assign elig[g]    = port_req[g] && (len_a[g] != '0);
  end

  // Masking with URG_MASK keeps every urgent bit in the expression while
  // only the configured port can ever trigger the override.
  assign urgent_hit = |(port_urgent & elig & URG_MASK);

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_grant;
    cand      = '0;
    if (urgent_hit) begin
      arb_found = 1'b1;
      arb_idx   = URG_IDX;
    end else begin
      // k = 4 wraps back to last_grant itself, so a lone requester that
      // was served last is still found.
      for (int unsigned k = 1; k <= 4; k++) begin
        cand = last_grant + 2'(k);
        if (!arb_found && elig[cand]) begin
          arb_found = 1'b1;
          arb_idx   = cand;
        end
      end
    end
  end

  // Pointer advance uses the latched burst length so it cannot be disturbed
  // by port_len changing mid-burst.
  always_comb begin
    len_ext   = {{(ASIZE+1-LEN_W){1'b0}}, cmd_len};
    ptr_next  = {1'b0, ptr[winner]} + len_ext;
    ptr_check = ptr_next + len_ext;
    wrap_now  = ptr_check > {1'b0, max_a[winner]};
    clear_now = clr_pend[winner] | port_clear[winner];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (|elig)    state_nxt = ARB;
      ARB:       state_nxt = arb_found ? ISSUE : IDLE;
      ISSUE:     if (cmd_ack)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (cmd_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    cmd_valid = (state == ISSUE);
    busy      = (state != IDLE);
  end

  // Datapath: pointers, latched command, grant bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) ptr[i] <= '0;
      clr_pend   <= '0;
      last_grant <= 2'd3;
      winner     <= '0;
      port_grant <= '0;
      port_wrap  <= '0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
    end else begin
      port_wrap <= '0;

      for (int unsigned i = 0; i < 4; i++) begin
        if (port_clear[i]) begin
          if (port_grant[i]) clr_pend[i] <= 1'b1;
          else               ptr[i]      <= start_a[i];
        end
      end

      if (state == ARB && arb_found) begin
        winner     <= arb_idx;
        cmd_addr   <= ptr[arb_idx];
        cmd_len    <= len_a[arb_idx];
        cmd_write  <= port_is_write[arb_idx];
        port_grant <= 4'b0001 << arb_idx;
      end

      if (state == WAIT_DONE && cmd_done) begin
        // A clear seen during the burst takes priority and suppresses wrap.
        if (clear_now || wrap_now) ptr[winner] <= start_a[winner];
        else                       ptr[winner] <= ptr_next[ASIZE-1:0];
        if (!clear_now && wrap_now) port_wrap[winner] <= 1'b1;
        clr_pend[winner] <= 1'b0;
        port_grant       <= '0;
        last_grant       <= winner;
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
module tb_sdram_burst_scheduler;

  localparam int AW = 23;
  localparam int LW = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      port_req, port_urgent, port_is_write, port_clear;
  logic [4*AW-1:0] port_start_addr, port_max_addr;
  logic [4*LW-1:0] port_len;
  logic [3:0]      port_grant, port_wrap;
  logic            cmd_valid, cmd_write, cmd_ack, cmd_done, busy;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;

  int total = 0;
  int bad   = 0;

  sdram_burst_scheduler #(.ASIZE(AW), .LEN_W(LW), .URGENT_PORT(1)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_urgent(port_urgent), .port_is_write(port_is_write),
    .port_start_addr(port_start_addr), .port_max_addr(port_max_addr),
    .port_len(port_len), .port_clear(port_clear),
    .port_grant(port_grant), .port_wrap(port_wrap),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ack(cmd_ack), .cmd_done(cmd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_port(input int p, input logic [AW-1:0] s, input logic [AW-1:0] m,
                          input logic [LW-1:0] l, input logic w);
    port_start_addr[p*AW +: AW] = s;
    port_max_addr[p*AW +: AW]   = m;
    port_len[p*LW +: LW]        = l;
    port_is_write[p]            = w;
  endtask

  task automatic do_reset();
    rst = 1'b1; port_req = '0; port_urgent = '0; port_clear = '0;
    cmd_ack = 1'b0; cmd_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear(input logic [3:0] m);
    port_clear = m;
    @(negedge clk);
    port_clear = '0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (cmd_valid === 1'b1);
  endtask

  task automatic ack_cycle();
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
  endtask

  task automatic done_cycle(output logic [3:0] wrap);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    wrap = port_wrap;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({cmd_valid, cmd_write, busy} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl: valid/write/busy=%b required 000", {cmd_valid, cmd_write, busy});
    end
    total++;
    if (cmd_addr !== '0 || cmd_len !== '0) begin
      bad++; $display("FAIL reset_cmd: addr=%h len=%h required 0/0", cmd_addr, cmd_len);
    end
    total++;
    if (port_grant !== 4'b0000 || port_wrap !== 4'b0000) begin
      bad++; $display("FAIL reset_ports: grant=%b wrap=%b required 0000/0000", port_grant, port_wrap);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_port();
    logic [AW-1:0] ea [5];
    logic [3:0]    w;
    bit            ok;
    ea = '{23'h00, 23'h10, 23'h20, 23'h30, 23'h00};
    do_reset();
    set_port(0, 23'h0, 23'h40, 11'h10, 1'b1);
    pulse_clear(4'b0001);
    port_req = 4'b0001;
    @(negedge clk);
    total++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL latency_c1: valid=%b busy=%b required 0/1", cmd_valid, busy);
    end
    @(negedge clk);
    total++;
    if (cmd_valid !== 1'b1) begin
      bad++; $display("FAIL latency_c2: valid=%b required 1", cmd_valid);
    end
    for (int i = 0; i < 5; i++) begin
      wait_valid(ok);
      total++;
      if (!ok || cmd_addr !== ea[i] || cmd_len !== 11'h10 || cmd_write !== 1'b1 || port_grant !== 4'b0001) begin
        bad++;
        $display("FAIL single_burst%0d: ok=%0d addr=%h len=%h wr=%b grant=%b required addr=%h len=010 wr=1 grant=0001",
                 i, ok, cmd_addr, cmd_len, cmd_write, port_grant, ea[i]);
      end
      ack_cycle();
      done_cycle(w);
      total++;
      if (w !== ((i == 3) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL single_wrap%0d: wrap=%b required %b", i, w, (i == 3) ? 4'b0001 : 4'b0000);
      end
    end
    port_req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [6];
    logic [3:0] w;
    bit         ok;
    eg = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 23'h0, 23'h1000, 11'h8, 1'b0);
    pulse_clear(4'b1111);
    port_req = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      wait_valid(ok);
      total++;
      if (!ok || port_grant !== eg[i] || cmd_addr !== ((i < 3) ? 23'h0 : 23'h8)) begin
        bad++;
        $display("FAIL rr_issue%0d: ok=%0d grant=%b addr=%h required grant=%b addr=%h",
                 i, ok, port_grant, cmd_addr, eg[i], (i < 3) ? 23'h0 : 23'h8);
      end
      ack_cycle();
      total++;
      if (port_grant !== eg[i] || cmd_valid !== 1'b0) begin
        bad++; $display("FAIL rr_wait%0d: grant=%b valid=%b required %b/0", i, port_grant, cmd_valid, eg[i]);
      end
      done_cycle(w);
      total++;
      if (port_grant !== 4'b0000 || w !== 4'b0000) begin
        bad++; $display("FAIL rr_done%0d: grant=%b wrap=%b required 0000/0000", i, port_grant, w);
      end
    end
    port_req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_urgent();
    logic [3:0] eg [5];
    logic [3:0] w;
    bit         ok;
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0100};
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 23'h0, 23'h1000, 11'h8, 1'b0);
    pulse_clear(4'b1111);
    port_req = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      wait_valid(ok);
      total++;
      if (!ok || port_grant !== eg[i]) begin
        bad++; $display("FAIL urgent_issue%0d: ok=%0d grant=%b required %b", i, ok, port_grant, eg[i]);
      end
      ack_cycle();
      // Urgent raised while ports 0 and 2 are in WAIT_DONE; dropped once served.
      if (i == 0 || i == 2) begin
        port_req = 4'b1111; port_urgent = 4'b0010;
      end else begin
        port_req = 4'b1101; port_urgent = 4'b0000;
      end
      done_cycle(w);
    end
    port_req = '0; port_urgent = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear_during_burst();
    logic [AW-1:0] ea [3];
    logic [3:0]    w;
    bit            ok;
    ea = '{23'h40, 23'h60, 23'h80};
    do_reset();
    set_port(2, 23'h40, 23'h200, 11'h20, 1'b0);
    pulse_clear(4'b0100);
    port_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      wait_valid(ok);
      total++;
      if (!ok || cmd_addr !== ea[i] || port_grant !== 4'b0100) begin
        bad++; $display("FAIL clr_addr%0d: ok=%0d addr=%h grant=%b required %h/0100", i, ok, cmd_addr, port_grant, ea[i]);
      end
      ack_cycle();
      if (i == 2) pulse_clear(4'b0100);
      done_cycle(w);
      total++;
      if (w !== 4'b0000) begin
        bad++; $display("FAIL clr_wrap%0d: wrap=%b required 0000", i, w);
      end
    end
    wait_valid(ok);
    total++;
    if (!ok || cmd_addr !== 23'h40) begin
      bad++; $display("FAIL clr_reload: ok=%0d addr=%h required 000040", ok, cmd_addr);
    end
    ack_cycle();
    port_req = '0;
    done_cycle(w);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_handshake_reset();
    bit ok;
    bit stable;
    bit quiet;
    do_reset();
    set_port(0, 23'h100, 23'h1000, 11'h8, 1'b1);
    pulse_clear(4'b0001);
    port_req = 4'b0001;
    wait_valid(ok);
    stable = ok;
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid !== 1'b1 || cmd_addr !== 23'h100 || cmd_len !== 11'h8 || cmd_write !== 1'b1)
        stable = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!stable || cmd_valid !== 1'b1 || cmd_addr !== 23'h100) begin
      bad++; $display("FAIL hold_stable: valid=%b addr=%h len=%h required 1/000100/008", cmd_valid, cmd_addr, cmd_len);
    end
    ack_cycle();
    total++;
    if (busy !== 1'b1 || cmd_valid !== 1'b0 || port_grant !== 4'b0001) begin
      bad++; $display("FAIL wait_state: busy=%b valid=%b grant=%b required 1/0/0001", busy, cmd_valid, port_grant);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_valid, cmd_write, busy} !== 3'b000 || port_grant !== 4'b0000 || port_wrap !== 4'b0000 ||
        cmd_addr !== '0 || cmd_len !== '0) begin
      bad++;
      $display("FAIL midburst_reset: valid=%b wr=%b busy=%b grant=%b wrap=%b addr=%h len=%h required all 0",
               cmd_valid, cmd_write, busy, port_grant, port_wrap, cmd_addr, cmd_len);
    end
    set_port(1, 23'h0, 23'h1000, 11'h0, 1'b0);
    port_req = 4'b0010; port_urgent = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 || port_grant !== 4'b0000 || busy !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL zero_len: valid=%b grant=%b busy=%b required 0/0000/0", cmd_valid, port_grant, busy);
    end
    port_req = '0; port_urgent = '0;
  endtask

  initial begin
    rst = 1'b1;
    port_req = '0; port_urgent = '0; port_is_write = '0; port_clear = '0;
    port_start_addr = '0; port_max_addr = '0; port_len = '0;
    cmd_ack = 1'b0; cmd_done = 1'b0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_urgent();
    test_clear_during_burst();
    test_handshake_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_burst_scheduler.md
# sdram_burst_scheduler

Burst scheduler that shares the single SDRAM controller command port among four FIFO-side requesters: camera write (port 0), display read (port 1), image-transfer read (port 2) and image-transfer write-back (port 3). It keeps a per-port address pointer that walks from a programmable start address toward a maximum address in fixed-length bursts, and issues one burst command at a time. It arbitrates round-robin, with an urgent override for the display read path. The block sits between the FIFO/request logic and the SDRAM command interface defined in `Sdram_Params.h`.

## Interface
Parameters:
- ASIZE, 23, SDRAM word-address width (matches `ASIZE`)
- LEN_W, 11, burst-length field width
- URGENT_PORT, 1, port index eligible for urgent override

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- port_req  in  4  per-port burst request, level; held while the port wants service
- port_urgent  in  4  per-port urgent flag; only bit URGENT_PORT is honoured
- port_is_write  in  4  1 = write burst, 0 = read burst
- port_start_addr  in  4*ASIZE  per-port start address; port i at [i*ASIZE +: ASIZE]
- port_max_addr  in  4*ASIZE  per-port exclusive upper bound
- port_len  in  4*LEN_W  per-port burst length in words
- port_clear  in  4  pulse; reloads that port's pointer with its start address
- port_grant  out  4  one-hot; high from command issue through burst completion
- port_wrap  out  4  one-cycle pulse when a port's pointer wraps to its start address
- cmd_valid  out  1  burst command valid
- cmd_write  out  1  burst direction
- cmd_addr  out  ASIZE  burst start address
- cmd_len  out  LEN_W  burst length
- cmd_ack  in  1  controller accepts command (valid & ack)
- cmd_done  in  1  one-cycle pulse at end of accepted burst
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ARB, ISSUE, WAIT_DONE.
- IDLE: if any eligible request is present, go to ARB. A request is eligible when port_req[i] is high and port_len[i] is non-zero. Zero-length requests are ignored permanently.
- ARB: choose a winner.
  - If port URGENT_PORT has both req and urgent asserted, it wins.
  - Otherwise round-robin, starting at index last_grant+1 mod 4.
  - Latch the winner's addr, len and is_write into cmd_* registers.
  - Set port_grant; go to ISSUE.
- ISSUE: cmd_valid=1. The cmd_* outputs stay stable until cmd_ack, then cmd_valid drops and the FSM goes to WAIT_DONE.
- WAIT_DONE: on cmd_done, update the winner's pointer, clear port_grant, set last_grant=winner, and return to IDLE.
- Pointer update, computed in ASIZE+1 bits:
  - next = ptr + len.
  - If next + len > max, next = start and port_wrap[winner] pulses.
- port_clear[i]:
  - When port i is not granted, ptr_i=start_i on the next edge.
  - When port i is granted, the clear is remembered; at cmd_done the pointer loads start instead of next, and port_wrap does not pulse.
- Pointers initialise to 0 on reset. Software/FSM must pulse port_clear before first use.
- Urgent override does not update the round-robin order except through last_grant.

## Timing
- Reset values: cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_len=0, port_grant=0, port_wrap=0, busy=0, state=IDLE, last_grant=3 (so port 0 is first in round-robin).
- Latency from req to cmd_valid: 2 cycles (IDLE→ARB, ARB→ISSUE).
- After cmd_done, the FSM returns to IDLE on the next edge. Minimum gap between cmd_valid bursts is 3 cycles.
- cmd_ack is ignored outside ISSUE. cmd_done is ignored outside WAIT_DONE, and is ignored if it arrives in the same cycle as cmd_ack.
- A req dropped after ARB does not cancel the burst. The issued burst always completes.
- Asserting rst mid-burst clears all outputs immediately, including cmd_valid. The SDRAM controller is reset by the same signal.

## Test plan
- Single port: port 0, start=0, max=0x40, len=0x10, req held.
  - Required: cmd_addr sequence 0x00, 0x10, 0x20, 0x30, then 0x00.
  - Required: port_wrap[0] pulses once, after the 0x30 burst.
  - Required: 2-cycle req→cmd_valid latency.
- Round-robin: ports 0, 2, 3 request continuously, none urgent.
  - Required: grant order 0, 2, 3, 0, 2, 3.
  - Required: each port_grant stays one-hot from issue to cmd_done.
- Urgent: ports 0 and 3 are mid-rotation; port 1 asserts req+urgent while port 0 is in WAIT_DONE.
  - Required: port 1 wins the next ARB, then rotation resumes at port 2.
- Clear during burst: port_clear[2] arrives while port 2 is granted at ptr=0x80 (start=0x40, len=0x20).
  - Required: after cmd_done, the next port 2 cmd_addr is 0x40.
  - Required: no port_wrap pulse.
- Handshake and reset: hold cmd_ack low for 5 cycles.
  - Required: cmd_addr/len are stable throughout and cmd_valid stays high.
  - Then assert rst in WAIT_DONE. Required: all outputs are 0 in the same cycle, and a zero-length req is never granted after release.
